// File: rtl/spi_host_ctrl.sv
// SPI host controller: accepts one register transaction per request and
// shifts out a command word followed by a data word, LSB first. Read data
// is sampled from spi_miso during the data word.
module spi_host_ctrl #(
  parameter int SPI_CMD_WIDTH  = 8,
  parameter int SPI_DATA_WIDTH = 8,
  parameter int SPI_ADDR_WIDTH = 3,
  parameter int CLK_DIV        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [SPI_ADDR_WIDTH-1:0] req_addr,
  input  logic [SPI_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  output logic [SPI_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      busy,
  output logic                      spi_clk,
  output logic                      spi_sel,
  output logic                      spi_mosi,
  input  logic                      spi_miso
);

  localparam int N      = SPI_CMD_WIDTH + SPI_DATA_WIDTH;
  localparam int BIT_W  = $clog2(N);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DIDX_W = (SPI_DATA_WIDTH > 1) ? $clog2(SPI_DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  state_e                    state_q, state_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [N-1:0]              shift_q, shift_d;
  logic                      write_q, write_d;
  logic                      sclk_q, sclk_d;
  logic                      sel_q, sel_d;
  logic                      mosi_q, mosi_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [SPI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      busy_q, busy_d;
  logic                      ready_q, ready_d;

  logic                      tick;
  logic [SPI_CMD_WIDTH-1:0]  cmd_w;
  logic [DIDX_W-1:0]         didx;

  // Divider tick marks the last clk cycle of each spi_clk half-period.
  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  // Next-state, shift and output logic for the transaction sequencer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    write_d     = write_q;
    sclk_d      = sclk_q;
    sel_d       = sel_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    cmd_w       = '0;
    cmd_w[0]    = req_write;
    cmd_w[SPI_ADDR_WIDTH:1] = req_addr;
    didx        = DIDX_W'(bit_q - BIT_W'(SPI_CMD_WIDTH));

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = ST_SETUP;
          shift_d = {req_wdata, cmd_w};
          write_d = req_write;
          sel_d   = 1'b0;
          mosi_d  = req_write;
          bit_d   = '0;
          if (req_write) rdata_d = '0;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            // Rising edge: capture miso during the data word of a read.
            sclk_d = 1'b1;
            if (!write_q && (bit_q >= BIT_W'(SPI_CMD_WIDTH))) rdata_d[didx] = spi_miso;
          end else begin
            // Falling edge: advance to the next bit or finish the frame.
            sclk_d = 1'b0;
            if (bit_q == BIT_W'(N - 1)) begin
              state_d = ST_HOLD;
              mosi_d  = 1'b0;
            end else begin
              bit_d   = bit_q + 1'b1;
              shift_d = shift_q >> 1;
              mosi_d  = shift_q[1];
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d     = ST_GAP;
          sel_d       = 1'b1;
          rsp_valid_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Divider restarts on every state change and is parked while idle.
    if ((state_d != state_q) || (state_q == ST_IDLE) || tick) div_d = '0;
    else                                                       div_d = div_q + 1'b1;

    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and registered-output flops, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled at the same edge.
    if (rst) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      write_q     <= 1'b0;
      sclk_q      <= 1'b0;
      sel_q       <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      write_q     <= write_d;
      sclk_q      <= sclk_d;
      sel_q       <= sel_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign busy      = busy_q;
  assign spi_clk   = sclk_q;
  assign spi_sel   = sel_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Directed bench for spi_host_ctrl: one instance with CLK_DIV=2 and one with
// CLK_DIV=1, each with a small SPI device model that returns dev_data on miso.
// Cycle c means the clock period following edge c, where edge 0 is the accept.
module tb_spi_host_ctrl;

  localparam int NB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance with CLK_DIV=2.
  logic       req_valid0 = 1'b0, req_write0 = 1'b0;
  logic [2:0] req_addr0 = '0;
  logic [7:0] req_wdata0 = '0;
  logic       req_ready0, rsp_valid0, busy0, sclk0, sel0, mosi0, miso0;
  logic [7:0] rsp_rdata0;

  // Instance with CLK_DIV=1.
  logic       req_valid1 = 1'b0, req_write1 = 1'b0;
  logic [2:0] req_addr1 = '0;
  logic [7:0] req_wdata1 = '0;
  logic       req_ready1, rsp_valid1, busy1, sclk1, sel1, mosi1, miso1;
  logic [7:0] rsp_rdata1;

  spi_host_ctrl #(.CLK_DIV(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .busy(busy0),
    .spi_clk(sclk0), .spi_sel(sel0), .spi_mosi(mosi0), .spi_miso(miso0)
  );

  spi_host_ctrl #(.CLK_DIV(1)) u_dut_fast (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .busy(busy1),
    .spi_clk(sclk1), .spi_sel(sel1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  // Device models: bit index = falling spi_clk edges since select fell.
  logic [7:0] dev_data0 = '0, dev_data1 = '0;
  logic [4:0] cnt0 = '0, cnt1 = '0;
  logic [4:0] idx0, idx1;

  always @(negedge sclk0 or posedge sel0) begin
    if (sel0) cnt0 <= '0;
    else      cnt0 <= cnt0 + 5'd1;
  end
  always @(negedge sclk1 or posedge sel1) begin
    if (sel1) cnt1 <= '0;
    else      cnt1 <= cnt1 + 5'd1;
  end

  always_comb begin
    idx0  = cnt0 - 5'd8;
    idx1  = cnt1 - 5'd8;
    miso0 = 1'b0;
    miso1 = 1'b0;
    if (cnt0 >= 5'd8 && cnt0 < 5'd16) miso0 = dev_data0[idx0[2:0]];
    if (cnt1 >= 5'd8 && cnt1 < 5'd16) miso1 = dev_data1[idx1[2:0]];
  end

  // Monitored view of whichever instance the current step targets.
  bit         use_fast = 1'b0;
  logic       m_ready, m_rsp, m_sclk, m_sel, m_mosi, m_busy;
  logic [7:0] m_rdata;
  always_comb begin
    if (use_fast) begin
      m_ready = req_ready1; m_rsp = rsp_valid1; m_sclk = sclk1;
      m_sel = sel1; m_mosi = mosi1; m_busy = busy1; m_rdata = rsp_rdata1;
    end else begin
      m_ready = req_ready0; m_rsp = rsp_valid0; m_sclk = sclk0;
      m_sel = sel0; m_mosi = mosi0; m_busy = busy0; m_rdata = rsp_rdata0;
    end
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic w, input logic [2:0] a, input logic [7:0] wd);
    if (use_fast) begin
      req_valid1 = v; req_write1 = w; req_addr1 = a; req_wdata1 = wd;
    end else begin
      req_valid0 = v; req_write0 = w; req_addr0 = a; req_wdata0 = wd;
    end
  endtask

  // Waits (bounded) for ready, presents one request; returns at cycle 0.
  task automatic issue(input logic w, input logic [2:0] a, input logic [7:0] wd, input string tag);
    for (int k = 0; k < 200 && !m_ready; k++) tick();
    check({tag, "_ready_before_accept"}, m_ready, 1'b1);
    set_req(1'b1, w, a, wd);
    tick();
    set_req(1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  // Observes one frame from cycle 0 to cycle (2N+2)*d and checks its timing,
  // mosi bit stream and response. poke_at >= 0 pulses a stray request then.
  task automatic watch_frame(input int d, input logic [15:0] exp_frame,
                             input logic [7:0] exp_rdata, input string tag,
                             input int poke_at);
    int rsp_at, ready_at, sel_rise, rises, rsp_n, last;
    logic [15:0] cap;
    logic [7:0]  rd_at_rsp;
    logic        prev_clk, clk_ok;
    rsp_at = -1; ready_at = -1; sel_rise = -1; rises = 0; rsp_n = 0;
    cap = '0; rd_at_rsp = '0; prev_clk = 1'b0; clk_ok = 1'b1;
    last = (2 * NB + 2) * d;
    for (int c = 0; c <= last; c++) begin
      if (m_sclk && !prev_clk) begin
        if (c != (2 * rises + 1) * d) clk_ok = 1'b0;
        if (rises < NB) cap[rises] = m_mosi;
        rises++;
      end
      if (!m_sclk && prev_clk && (c != 2 * rises * d)) clk_ok = 1'b0;
      if (m_rsp) begin
        rsp_n++;
        if (rsp_at < 0) begin
          rsp_at    = c;
          rd_at_rsp = m_rdata;
        end
      end
      if (m_sel && sel_rise < 0) sel_rise = c;
      if (m_ready && ready_at < 0) ready_at = c;
      prev_clk = m_sclk;
      if (c == poke_at)     set_req(1'b1, 1'b1, 3'd1, 8'hFF);
      if (c == poke_at + 1) set_req(1'b0, 1'b0, 3'd0, 8'h00);
      if (c < last) tick();
    end
    check({tag, "_spi_clk_rises"},  rises, NB);
    check({tag, "_spi_clk_timing"}, clk_ok, 1'b1);
    check({tag, "_mosi_frame"},     cap, exp_frame);
    check({tag, "_sel_rise_cycle"}, sel_rise, (2 * NB + 1) * d);
    check({tag, "_rsp_cycle"},      rsp_at, (2 * NB + 1) * d);
    check({tag, "_rsp_count"},      rsp_n, 1);
    check({tag, "_rdata"},          rd_at_rsp, exp_rdata);
    check({tag, "_ready_cycle"},    ready_at, (2 * NB + 2) * d);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int early, rsp_n, sel_low;

    // Reset state, observed while rst is held.
    #12;
    check("rst_sel",       sel0, 1'b1);
    check("rst_spi_clk",   sclk0, 1'b0);
    check("rst_mosi",      mosi0, 1'b0);
    check("rst_rsp_valid", rsp_valid0, 1'b0);
    check("rst_rdata",     rsp_rdata0, 8'h00);
    check("rst_busy",      busy0, 1'b0);
    #10;
    rst = 1'b0;
    tick();
    check("post_rst_ready", req_ready0, 1'b1);

    // Read addr 3, device returns 0x3C; cmd 0x06 with zero data word.
    use_fast = 1'b0;
    dev_data0 = 8'h3C;
    issue(1'b0, 3'd3, 8'h00, "t2");
    check("t2_busy_at_accept", busy0, 1'b1);
    check("t2_sel_at_accept",  sel0, 1'b0);
    watch_frame(2, 16'h0006, 8'h3C, "t2", -1);

    // Write addr 5 data 0xA5; cmd 0x0B. Prior read data is cleared at accept.
    dev_data0 = 8'hFF;
    issue(1'b1, 3'd5, 8'hA5, "t1");
    check("t1_rdata_cleared", rsp_rdata0, 8'h00);
    watch_frame(2, 16'hA50B, 8'h00, "t1", -1);

    // req_valid held across two requests; second samples the new fields.
    for (int k = 0; k < 200 && !req_ready0; k++) tick();
    set_req(1'b1, 1'b1, 3'd1, 8'h11);
    tick();
    set_req(1'b1, 1'b1, 3'd2, 8'h22);
    early = 0;
    rsp_n = 0;
    for (int c = 0; c < 69; c++) begin
      if (c >= 1 && c <= 67 && req_ready0) early++;
      if (rsp_valid0) rsp_n++;
      if (c == 68) begin
        check("t3_ready_cycle68", req_ready0, 1'b1);
        check("t3_sel_gap_c68",   sel0, 1'b1);
      end
      tick();
    end
    check("t3_ready_low_1_67",   early, 0);
    check("t3_first_rsp_count",  rsp_n, 1);
    check("t3_second_accept",    sel0, 1'b0);
    set_req(1'b0, 1'b0, 3'd0, 8'h00);
    watch_frame(2, 16'h2205, 8'h00, "t3b", -1);

    // Reset mid-frame at cycle 20: outputs drop immediately, no response.
    issue(1'b1, 3'd7, 8'h5A, "t4");
    repeat (20) tick();
    rst = 1'b1;
    #1;
    check("t4_rst_sel",     sel0, 1'b1);
    check("t4_rst_spi_clk", sclk0, 1'b0);
    check("t4_rst_busy",    busy0, 1'b0);
    check("t4_rst_rsp",     rsp_valid0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    rsp_n = 0;
    sel_low = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (rsp_valid0) rsp_n++;
      if (!sel0) sel_low++;
    end
    check("t4_no_rsp_after_abort", rsp_n, 0);
    check("t4_sel_idle_after",     sel_low, 0);
    dev_data0 = 8'h96;
    issue(1'b0, 3'd4, 8'h00, "t4b");
    watch_frame(2, 16'h0008, 8'h96, "t4b", -1);

    // CLK_DIV=1 read addr 2, device returns 0xC3.
    use_fast = 1'b1;
    dev_data1 = 8'hC3;
    issue(1'b0, 3'd2, 8'h00, "t5");
    watch_frame(1, 16'h0004, 8'hC3, "t5", -1);

    // Stray request pulsed while busy is dropped; one response only.
    use_fast = 1'b0;
    issue(1'b1, 3'd6, 8'h7E, "t6");
    watch_frame(2, 16'h7E0D, 8'h00, "t6", 10);
    rsp_n = 0;
    sel_low = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (rsp_valid0) rsp_n++;
      if (!sel0) sel_low++;
    end
    check("t6_no_extra_rsp",   rsp_n, 0);
    check("t6_no_extra_frame", sel_low, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
